// File: rtl/mem_rw_initiator.sv
// mem_rw_initiator
//   Requester side of the r_*/w_* simulation memory port. Accepts one load or
//   store at a time over a valid/ready request channel, drives word-indexed
//   read/write strobes with lane-shifted data and byte masks, and returns the
//   load result (shifted, masked, sign/zero extended) on a held response.
//
// Configuration macro: MEM_RW_INIT_SPLIT_EN
//   defined   : accesses crossing an 8-byte word are split into two beats
//   undefined : crossing accesses return resp_err, no strobes are issued
//
// Ports
//   clock, reset_n            clock (posedge), synchronous active-low reset
//   req_valid/req_ready       request handshake (ready only in IDLE)
//   req_wen/addr/size/signed/wdata  request fields, latched at accept
//   resp_valid/resp_ready     response handshake, response held until accepted
//   resp_rdata/resp_err       load result (0 for stores/errors), error flag
//   r_enable/r_index/r_data   read strobe, word index, read data (next cycle)
//   w_enable/w_index/w_data/w_mask  write strobe, word index, lane data, bit mask
module mem_rw_initiator #(
  parameter logic [63:0] MEM_BASE  = 64'h8000_0000,
  parameter logic [63:0] MEM_BYTES = 64'h8000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [63:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        r_enable,
  output logic [63:0] r_index,
  input  logic [63:0] r_data,
  output logic        w_enable,
  output logic [63:0] w_index,
  output logic [63:0] w_data,
  output logic [63:0] w_mask
);

`ifdef MEM_RW_INIT_SPLIT_EN
  typedef enum logic [2:0] {
    S_IDLE, S_RD0, S_RD1, S_RCAP, S_WR0, S_WR1, S_RESP
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_RD0, S_RCAP, S_WR0, S_RESP
  } state_t;
`endif

  state_t      r_state;
  state_t      w_next;
  logic        r_live;
  logic        r_signed;
  logic [1:0]  r_size;
  logic [2:0]  r_off;
  logic [63:0] r_idx;
  logic [63:0] r_wdata;
  logic [63:0] r_rdata;
  logic        r_err;
`ifdef MEM_RW_INIT_SPLIT_EN
  logic        r_cross;
  logic [63:0] r_lo;
`endif

  // Accept-time checks (65-bit so the window end cannot wrap)
  logic [3:0]  w_bytes;
  logic [64:0] w_end;
  logic [64:0] w_lim;
  logic        w_range_err;
  logic        w_cross;
  logic        w_acc_err;
  logic        w_accept;

  assign w_bytes     = 4'd1 << req_size;
  assign w_end       = {1'b0, req_addr} + {61'd0, w_bytes};
  assign w_lim       = {1'b0, MEM_BASE} + {1'b0, MEM_BYTES};
  assign w_range_err = (req_addr < MEM_BASE) || (w_end > w_lim);
  assign w_cross     = ({1'b0, req_addr[2:0]} + w_bytes) > 4'd8;
`ifdef MEM_RW_INIT_SPLIT_EN
  assign w_acc_err   = w_range_err;
`else
  assign w_acc_err   = w_range_err | w_cross;
`endif
  assign w_accept    = (r_state == S_IDLE) && r_live && req_valid;

  // Lane shift helpers for the latched access
  logic [63:0] w_bmask;
  logic [5:0]  w_shift;

  always_comb begin
    case (r_size)
      2'd0:    w_bmask = 64'h0000_0000_0000_00FF;
      2'd1:    w_bmask = 64'h0000_0000_0000_FFFF;
      2'd2:    w_bmask = 64'h0000_0000_FFFF_FFFF;
      default: w_bmask = '1;
    endcase
  end

  assign w_shift = {r_off, 3'b000};

  // Load result: the two beats form a 128-bit window shifted down by the offset
  logic [63:0]  w_lo;
  logic [63:0]  w_hi;
  logic [127:0] w_cat;
  logic [63:0]  w_raw;
  logic         w_sign;
  logic [63:0]  w_ext;

`ifdef MEM_RW_INIT_SPLIT_EN
  logic [5:0]  w_rshift;
  assign w_rshift = {3'd0 - r_off, 3'b000};
  assign w_lo     = r_cross ? r_lo   : r_data;
  assign w_hi     = r_cross ? r_data : '0;
`else
  assign w_lo     = r_data;
  assign w_hi     = '0;
`endif

  assign w_cat = {w_hi, w_lo} >> w_shift;
  assign w_raw = w_cat[63:0] & w_bmask;

  always_comb begin
    case (r_size)
      2'd0:    w_sign = w_raw[7];
      2'd1:    w_sign = w_raw[15];
      2'd2:    w_sign = w_raw[31];
      default: w_sign = 1'b0;
    endcase
  end

  assign w_ext = (r_signed && w_sign) ? (w_raw | ~w_bmask) : w_raw;

  // Next state and strobes
  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    r_enable   = 1'b0;
    r_index    = '0;
    w_enable   = 1'b0;
    w_index    = '0;
    w_data     = '0;
    w_mask     = '0;
    case (r_state)
      S_IDLE: begin
        req_ready = r_live;
        if (w_accept) begin
          if (w_acc_err)    w_next = S_RESP;
          else if (req_wen) w_next = S_WR0;
          else              w_next = S_RD0;
        end
      end
      S_RD0: begin
        r_enable = 1'b1;
        r_index  = r_idx;
`ifdef MEM_RW_INIT_SPLIT_EN
        w_next   = r_cross ? S_RD1 : S_RCAP;
`else
        w_next   = S_RCAP;
`endif
      end
`ifdef MEM_RW_INIT_SPLIT_EN
      S_RD1: begin
        r_enable = 1'b1;
        r_index  = r_idx + 64'd1;
        w_next   = S_RCAP;
      end
`endif
      S_RCAP: w_next = S_RESP;
      S_WR0: begin
        w_enable = 1'b1;
        w_index  = r_idx;
        w_data   = r_wdata << w_shift;
        w_mask   = w_bmask << w_shift;
`ifdef MEM_RW_INIT_SPLIT_EN
        w_next   = r_cross ? S_WR1 : S_RESP;
`else
        w_next   = S_RESP;
`endif
      end
`ifdef MEM_RW_INIT_SPLIT_EN
      S_WR1: begin
        w_enable = 1'b1;
        w_index  = r_idx + 64'd1;
        w_data   = r_wdata >> w_rshift;
        w_mask   = w_bmask >> w_rshift;
        w_next   = S_RESP;
      end
`endif
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_live   <= 1'b0;
      r_signed <= 1'b0;
      r_size   <= '0;
      r_off    <= '0;
      r_idx    <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
`ifdef MEM_RW_INIT_SPLIT_EN
      r_cross  <= 1'b0;
      r_lo     <= '0;
`endif
    end else begin
      r_live  <= 1'b1;
      r_state <= w_next;
      if (w_accept) begin
        r_signed <= req_signed;
        r_size   <= req_size;
        r_off    <= req_addr[2:0];
        r_idx    <= (req_addr - MEM_BASE) >> 3;
        r_wdata  <= req_wdata;
        r_rdata  <= '0;
        r_err    <= w_acc_err;
`ifdef MEM_RW_INIT_SPLIT_EN
        r_cross  <= w_cross;
`endif
      end
`ifdef MEM_RW_INIT_SPLIT_EN
      if (r_state == S_RD1) r_lo <= r_data;
`endif
      if (r_state == S_RCAP) r_rdata <= w_ext;
    end
  end

endmodule

// File: tb/tb_mem_rw_initiator.sv
module tb_mem_rw_initiator;

  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam logic [63:0] BYTES = 64'h8000_0000;

  logic        clock;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [63:0] req_addr;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        r_enable;
  logic [63:0] r_index;
  logic [63:0] r_data;
  logic        w_enable;
  logic [63:0] w_index;
  logic [63:0] w_data;
  logic [63:0] w_mask;

  mem_rw_initiator #(.MEM_BASE(BASE), .MEM_BYTES(BYTES)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .r_enable(r_enable), .r_index(r_index), .r_data(r_data),
    .w_enable(w_enable), .w_index(w_index), .w_data(w_data), .w_mask(w_mask)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  // Memory helper (word array) and reference byte model
  logic [63:0] wmem [longint unsigned];
  logic [7:0]  bmem [longint unsigned];

  function automatic logic [63:0] word_rd(input logic [63:0] idx);
    return wmem.exists(idx) ? wmem[idx] : 64'd0;
  endfunction

  function automatic logic [7:0] byte_rd(input logic [63:0] a);
    return bmem.exists(a) ? bmem[a] : 8'd0;
  endfunction

  typedef struct {
    bit          wr;
    logic [63:0] idx;
    logic [63:0] data;
    logic [63:0] mask;
  } beat_t;

  beat_t       log_q[$];
  bit          pend_r = 1'b0;
  logic [63:0] pend_idx = '0;

  always @(negedge clock) begin
    logic [63:0] idle_bits;
    beat_t bt;
    idle_bits = '0;
    if (!r_enable) idle_bits = idle_bits | r_index;
    if (!w_enable) idle_bits = idle_bits | w_index | w_data | w_mask;
    check("strobe_excl", {63'd0, r_enable & w_enable}, 64'd0);
    check("idle_strobe_zero", idle_bits, 64'd0);
    pend_r   = r_enable;
    pend_idx = r_index;
    if (r_enable) begin
      bt.wr = 1'b0; bt.idx = r_index; bt.data = '0; bt.mask = '0;
      log_q.push_back(bt);
    end
    if (w_enable) begin
      bt.wr = 1'b1; bt.idx = w_index; bt.data = w_data & w_mask; bt.mask = w_mask;
      log_q.push_back(bt);
      wmem[w_index] = (word_rd(w_index) & ~w_mask) | (w_data & w_mask);
    end
  end

  always @(posedge clock) begin
    r_data <= pend_r ? word_rd(pend_idx) : {$urandom, $urandom};
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("req_ready_wait", {63'd0, req_ready}, 64'd1);
  endtask

  task automatic do_req(input bit wen, input logic [63:0] addr, input logic [1:0] size,
                        input bit sgn, input logic [63:0] wdata, input int hold,
                        output logic [63:0] got_rdata, output logic got_err);
    int          n, nb, lat, exp_lat;
    bit          err;
    logic [63:0] e_idx[2], e_mask[2], e_data[2];
    logic [63:0] a, w, exp_rd, v;
    logic [2:0]  l;

    n   = 1 << size;
    err = (addr < BASE) || (addr + 64'(n) > BASE + BYTES);
    nb  = 0;
    for (int b = 0; b < n; b++) begin
      a = addr + 64'(b);
      w = (a - BASE) >> 3;
      l = a[2:0];
      if (nb == 0 || e_idx[nb-1] != w) begin
        e_idx[nb] = w; e_mask[nb] = '0; e_data[nb] = '0;
        nb++;
      end
      e_mask[nb-1] = e_mask[nb-1] | (64'hFF << (8 * l));
      e_data[nb-1] = e_data[nb-1] | ({56'd0, wdata[8*b +: 8]} << (8 * l));
    end
`ifndef MEM_RW_INIT_SPLIT_EN
    if (nb > 1) err = 1'b1;
`endif
    if (err) nb = 0;
    exp_lat = err ? 1 : (wen ? nb + 1 : nb + 2);
    exp_rd  = '0;
    if (!err && !wen) begin
      v = '0;
      for (int b = 0; b < n; b++) v = v | ({56'd0, byte_rd(addr + 64'(b))} << (8 * b));
      if (sgn && n < 8 && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
      exp_rd = v;
    end
    if (!err && wen)
      for (int b = 0; b < n; b++) bmem[addr + 64'(b)] = wdata[8*b +: 8];

    wait_ready();
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_size = size;
    req_signed = sgn; req_wdata = wdata;
    @(posedge clock); #1;
    req_valid = 1'b0;
    log_q.delete();
    check("req_ready_busy", {63'd0, req_ready}, 64'd0);
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge clock); #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(exp_lat));
    check("resp_err", {63'd0, resp_err}, {63'd0, err});
    check("resp_rdata", resp_rdata, exp_rd);
    got_rdata = resp_rdata;
    got_err   = resp_err;
    for (int h = 0; h < hold; h++) begin
      @(posedge clock); #1;
      check("hold_valid", {63'd0, resp_valid}, 64'd1);
      check("hold_rdata", resp_rdata, exp_rd);
      check("hold_err", {63'd0, resp_err}, {63'd0, err});
      check("hold_req_ready", {63'd0, req_ready}, 64'd0);
    end
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
    check("post_hs_valid", {63'd0, resp_valid}, 64'd0);
    check("post_hs_ready", {63'd0, req_ready}, 64'd1);
    check("beat_count", 64'(log_q.size()), 64'(nb));
    for (int i = 0; i < nb && i < log_q.size(); i++) begin
      check("beat_dir", {63'd0, log_q[i].wr}, {63'd0, wen});
      check("beat_idx", log_q[i].idx, e_idx[i]);
      if (wen) begin
        check("beat_mask", log_q[i].mask, e_mask[i]);
        check("beat_data", log_q[i].data, e_data[i]);
      end
    end
  endtask

  initial begin
    logic [63:0] rd;
    logic        er;
    logic [63:0] addr;
    logic [1:0]  sz;

    reset_n = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_addr = '0;
    req_size = '0; req_signed = 1'b0; req_wdata = '0; resp_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_req_ready", {63'd0, req_ready}, 64'd0);
    check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    check("rst_strobes", {62'd0, r_enable, w_enable}, 64'd0);
    check("rst_rdata", resp_rdata, 64'd0);
    check("rst_err", {63'd0, resp_err}, 64'd0);
    reset_n = 1'b1;
    @(posedge clock); #1;
    check("rel_req_ready", {63'd0, req_ready}, 64'd1);

    do_req(1'b1, 64'h8000_0010, 2'd3, 1'b0, 64'h1122334455667788, 0, rd, er);
    do_req(1'b0, 64'h8000_0010, 2'd3, 1'b0, '0, 0, rd, er);
    check("spec_ld8", rd, 64'h1122334455667788);
    do_req(1'b1, 64'h8000_0013, 2'd0, 1'b0, 64'hAB, 0, rd, er);
    do_req(1'b0, 64'h8000_0013, 2'd0, 1'b1, '0, 0, rd, er);
    check("spec_ld1_signed", rd, 64'hFFFF_FFFF_FFFF_FFAB);
    do_req(1'b0, 64'h8000_0013, 2'd0, 1'b0, '0, 0, rd, er);
    check("spec_ld1_unsigned", rd, 64'hAB);
    do_req(1'b1, 64'h8000_0010, 2'd3, 1'b0, 64'h0807060504030201, 0, rd, er);
    do_req(1'b1, 64'h8000_0018, 2'd3, 1'b0, 64'h100F0E0D0C0B0A09, 0, rd, er);
    do_req(1'b0, 64'h8000_0016, 2'd2, 1'b0, '0, 0, rd, er);
`ifdef MEM_RW_INIT_SPLIT_EN
    check("spec_cross_ld", rd, 64'h0A090807);
`else
    check("spec_cross_err", {63'd0, er}, 64'd1);
`endif
    do_req(1'b0, 64'h7FFF_FFF8, 2'd3, 1'b0, '0, 0, rd, er);
    check("spec_low_err", {63'd0, er}, 64'd1);
    do_req(1'b1, 64'h1_0000_0000, 2'd0, 1'b0, 64'h55, 0, rd, er);
    check("spec_high_err", {63'd0, er}, 64'd1);
    do_req(1'b0, 64'h8000_0010, 2'd3, 1'b0, '0, 5, rd, er);

    // Reset while the read beat is on the bus
    wait_ready();
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 64'h8000_0020; req_size = 2'd3;
    @(posedge clock); #1;
    req_valid = 1'b0;
    check("rd0_strobe", {63'd0, r_enable}, 64'd1);
    reset_n = 1'b0;
    @(posedge clock); #1;
    log_q.delete();
    check("midrst_strobes", {62'd0, r_enable, w_enable}, 64'd0);
    check("midrst_valid", {63'd0, resp_valid}, 64'd0);
    check("midrst_ready", {63'd0, req_ready}, 64'd0);
    check("midrst_idx", r_index | w_index | w_data | w_mask, 64'd0);
    reset_n = 1'b1;
    @(posedge clock); #1;
    check("midrst_rel_ready", {63'd0, req_ready}, 64'd1);
    repeat (3) @(posedge clock);
    #1;
    check("midrst_no_strobe", 64'(log_q.size()), 64'd0);

    for (int t = 0; t < 300; t++) begin
      sz = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0:       addr = BASE - 64'($urandom_range(1, 16));
        1:       addr = BASE + BYTES - 64'($urandom_range(0, 9));
        2:       addr = (BASE + 64'($urandom_range(0, 63))) & ~((64'd1 << sz) - 64'd1);
        default: addr = BASE + 64'($urandom_range(0, 63));
      endcase
      do_req(1'($urandom), addr, sz, 1'($urandom), {$urandom, $urandom},
             int'($urandom_range(0, 2)), rd, er);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
